// File: rtl/stopwatch_counter_if.sv
// Button-pulse inputs and BCD display outputs of the stopwatch counter.
// master: controller/bench side; slave: stopwatch_counter side.
interface stopwatch_counter_if;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [3:0] cs_ones;
   logic [3:0] cs_tens;
   logic [3:0] s_ones;
   logic [3:0] s_tens;
   logic [3:0] m_ones;
   logic [3:0] m_tens;
   logic       running;
   logic       overflow;

   modport master (
      output start_stop, clear, lap,
      input  cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens, running, overflow
   );

   modport slave (
      input  start_stop, clear, lap,
      output cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens, running, overflow
   );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch timebase: prescaler to TICK_HZ, mm:ss.cc BCD chain, IDLE/RUN/PAUSE control.
// Optional lap freeze of the display when STOPWATCH_LAP_EN is defined.
//
// state | meaning
// IDLE  | count zero, stopped, prescaler held at 0
// RUN   | prescaler counting, digits advance on each tick
// PAUSE | prescaler and digits hold, resume continues the partial period
module stopwatch_counter #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int TICK_HZ     = 100
) (
   input logic                clk,
   input logic                rst_n,
   stopwatch_counter_if.slave sw
);
   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    cs_ones_q, cs_tens_q, s_ones_q, s_tens_q, m_ones_q, m_tens_q;
   logic [3:0]    cs_ones_d, cs_tens_d, s_ones_d, s_tens_d, m_ones_d, m_tens_d;
   logic          overflow_q, overflow_d;
   logic          tick;
   logic          c0, c1, c2, c3, c4, c5;
   logic [23:0]   live;
   logic [23:0]   disp;

   function automatic logic [3:0] step(input logic [3:0] d, input logic wrap);
      return wrap ? 4'd0 : d + 4'd1;
   endfunction

   always_comb begin
      state_d = state_q;
      if (sw.clear) begin
         state_d = IDLE;
      end else if (sw.start_stop) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

   always_comb begin
      presc_d = presc_q;
      if (sw.clear || (state_q == IDLE)) begin
         presc_d = '0;
      end else if (state_q == RUN) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
   end

   // Carry terms ripple through all six digits in a single cycle.
   assign c0 = (cs_ones_q >= 4'd9);
   assign c1 = c0 && (cs_tens_q >= 4'd9);
   assign c2 = c1 && (s_ones_q >= 4'd9);
   assign c3 = c2 && (s_tens_q >= 4'd5);
   assign c4 = c3 && (m_ones_q >= 4'd9);
   assign c5 = c4 && (m_tens_q >= 4'd5);

   always_comb begin
      cs_ones_d  = cs_ones_q;
      cs_tens_d  = cs_tens_q;
      s_ones_d   = s_ones_q;
      s_tens_d   = s_tens_q;
      m_ones_d   = m_ones_q;
      m_tens_d   = m_tens_q;
      overflow_d = 1'b0;
      if (sw.clear) begin
         cs_ones_d = '0;
         cs_tens_d = '0;
         s_ones_d  = '0;
         s_tens_d  = '0;
         m_ones_d  = '0;
         m_tens_d  = '0;
      end else if (tick) begin
         cs_ones_d  = step(cs_ones_q, c0);
         cs_tens_d  = c0 ? step(cs_tens_q, c1) : cs_tens_q;
         s_ones_d   = c1 ? step(s_ones_q, c2)  : s_ones_q;
         s_tens_d   = c2 ? step(s_tens_q, c3)  : s_tens_q;
         m_ones_d   = c3 ? step(m_ones_q, c4)  : m_ones_q;
         m_tens_d   = c4 ? step(m_tens_q, c5)  : m_tens_q;
         overflow_d = c5;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         cs_ones_q  <= '0;
         cs_tens_q  <= '0;
         s_ones_q   <= '0;
         s_tens_q   <= '0;
         m_ones_q   <= '0;
         m_tens_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         cs_ones_q  <= cs_ones_d;
         cs_tens_q  <= cs_tens_d;
         s_ones_q   <= s_ones_d;
         s_tens_q   <= s_tens_d;
         m_ones_q   <= m_ones_d;
         m_tens_q   <= m_tens_d;
         overflow_q <= overflow_d;
      end
   end

   assign live = {m_tens_q, m_ones_q, s_tens_q, s_ones_q, cs_tens_q, cs_ones_q};

`ifdef STOPWATCH_LAP_EN
   logic        frozen_q, frozen_d;
   logic [23:0] snap_q, snap_d;

   always_comb begin
      frozen_d = frozen_q;
      snap_d   = snap_q;
      if (sw.clear) begin
         frozen_d = 1'b0;
      end else if (sw.lap && (state_q != IDLE)) begin
         frozen_d = !frozen_q;
         if (!frozen_q) snap_d = live;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frozen_q <= 1'b0;
         snap_q   <= '0;
      end else begin
         frozen_q <= frozen_d;
         snap_q   <= snap_d;
      end
   end

   assign disp = frozen_q ? snap_q : live;
`else
   logic lap_unused;
   assign lap_unused = sw.lap;
   assign disp       = live;
`endif

   assign sw.m_tens   = disp[23:20];
   assign sw.m_ones   = disp[19:16];
   assign sw.s_tens   = disp[15:12];
   assign sw.s_ones   = disp[11:8];
   assign sw.cs_tens  = disp[7:4];
   assign sw.cs_ones  = disp[3:0];
   assign sw.running  = (state_q == RUN);
   assign sw.overflow = overflow_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter at DIV=10: expected display events are
// queued with their edge number and matched by a monitor on every output change.
module tb_stopwatch_counter;
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   mon_skip = 1'b0;

   typedef struct {
      logic [25:0] val;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   stopwatch_counter_if sw();

   stopwatch_counter #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .sw   (sw)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [25:0] obs();
      return {sw.overflow, sw.running, sw.m_tens, sw.m_ones, sw.s_tens, sw.s_ones,
              sw.cs_tens, sw.cs_ones};
   endfunction

   function automatic logic [23:0] to_disp(input int t);
      int cs, s, m;
      cs = t % 100;
      s  = (t / 100) % 60;
      m  = (t / 6000) % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
   endfunction

   task automatic push(input bit ov, input bit run, input int t, input int c);
      exp_t e;
      e.val = {ov, run, to_disp(t)};
      e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic push_ticks(input int first, input int n, input int c_first);
      for (int i = 0; i < n; i++) push(1'b0, 1'b1, first + i, c_first + 10 * i);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s got=%h exp=%h (cyc %0d)", name, got, expv, cyc);
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Drive the pulse so that it is sampled by posedge number edge_n.
   task automatic pulse_at(input int edge_n, input bit ss, input bit clr, input bit lp);
      wait_until(edge_n - 1);
      sw.start_stop = ss;
      sw.clear      = clr;
      sw.lap        = lp;
      @(negedge clk);
      sw.start_stop = 1'b0;
      sw.clear      = 1'b0;
      sw.lap        = 1'b0;
   endtask

   logic [25:0] prev = '0;
   always @(negedge clk) begin
      logic [25:0] cur;
      exp_t        e;
      cur = obs();
      if (!rst_n || mon_skip) begin
         prev = cur;
      end else if (cur !== prev) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_change got=%h at cyc %0d", cur, cyc);
         end else begin
            e = exp_q.pop_front();
            if (cur === e.val && cyc == e.cyc) n_pass++;
            else $display("FAIL scoreboard got=%h@%0d exp=%h@%0d", cur, cyc, e.val, e.cyc);
         end
         prev = cur;
      end
   end

   initial begin
      int e, p, r, q, s, c, e2, e3, l, l2, ce;
      rst_n         = 1'b0;
      sw.start_stop = 1'b0;
      sw.clear      = 1'b0;
      sw.lap        = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", 32'(obs()), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // First tick 10 cycles after RUN entry, then one second of counting.
      e = cyc + 1;
      push(1'b0, 1'b1, 0, e);
      pulse_at(e, 1'b1, 1'b0, 1'b0);
      push_ticks(1, 100, e + 10);
      wait_until(e + 1000);
      check("run_1s", 32'(obs()), 32'({2'b01, to_disp(100)}));

      // Pause with the prescaler left at 4; resume finishes the period in 6 cycles.
      p = e + 1004;
      push(1'b0, 1'b0, 100, p);
      pulse_at(p, 1'b1, 1'b0, 1'b0);
      wait_until(p + 50);
      check("pause_hold", 32'(obs()), 32'({2'b00, to_disp(100)}));
      r = p + 51;
      push(1'b0, 1'b1, 100, r);
      pulse_at(r, 1'b1, 1'b0, 1'b0);
      push_ticks(101, 5, r + 6);
      q = r + 50;
      push(1'b0, 1'b0, 105, q);
      pulse_at(q, 1'b1, 1'b0, 1'b0);
      wait_until(q + 2);

      // Preload 59:59.99 while paused, then wrap.
      mon_skip = 1'b1;
      force dut.cs_ones_q = 4'd9;
      force dut.cs_tens_q = 4'd9;
      force dut.s_ones_q  = 4'd9;
      force dut.s_tens_q  = 4'd5;
      force dut.m_ones_q  = 4'd9;
      force dut.m_tens_q  = 4'd5;
      repeat (2) @(negedge clk);
      release dut.cs_ones_q;
      release dut.cs_tens_q;
      release dut.s_ones_q;
      release dut.s_tens_q;
      release dut.m_ones_q;
      release dut.m_tens_q;
      @(negedge clk);
      @(negedge clk);
      mon_skip = 1'b0;
      check("preload", 32'(obs()), 32'({2'b00, to_disp(359999)}));
      s = cyc + 1;
      push(1'b0, 1'b1, 359999, s);
      pulse_at(s, 1'b1, 1'b0, 1'b0);
      push(1'b1, 1'b1, 0, s + 6);
      push(1'b0, 1'b1, 0, s + 7);
      push_ticks(1, 3, s + 16);
      wait_until(s + 6);
      check("overflow_high", 32'(sw.overflow), 32'd1);
      wait_until(s + 7);
      check("overflow_low", 32'(sw.overflow), 32'd0);
      check("run_after_wrap", 32'(sw.running), 32'd1);

      // clear and start_stop together: clear wins.
      c = s + 40;
      push(1'b0, 1'b0, 0, c);
      pulse_at(c, 1'b1, 1'b1, 1'b0);
      wait_until(c + 30);
      check("clear_wins_idle", 32'(obs()), 32'd0);

      // Restart proves prescaler was zeroed; reset asynchronously at 00:03.47.
      e2 = c + 31;
      push(1'b0, 1'b1, 0, e2);
      pulse_at(e2, 1'b1, 1'b0, 1'b0);
      push_ticks(1, 347, e2 + 10);
      wait_until(e2 + 3473);
      check("pre_reset", 32'(obs()), 32'({2'b01, to_disp(347)}));
      #2 rst_n = 1'b0;
      #1 check("async_reset", 32'(obs()), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("idle_after_reset", 32'(obs()), 32'd0);

      // Lap: frozen at 00:00.25 with the feature, ignored without it.
      e3 = cyc + 1;
      push(1'b0, 1'b1, 0, e3);
      pulse_at(e3, 1'b1, 1'b0, 1'b0);
      push_ticks(1, 25, e3 + 10);
`ifndef STOPWATCH_LAP_EN
      push_ticks(26, 20, e3 + 260);
`endif
      l = e3 + 251;
      pulse_at(l, 1'b0, 1'b0, 1'b1);
      wait_until(e3 + 400);
`ifdef STOPWATCH_LAP_EN
      check("lap_frozen", 32'(obs()), 32'({2'b01, to_disp(25)}));
`else
      check("lap_ignored", 32'(obs()), 32'({2'b01, to_disp(40)}));
`endif
      l2 = e3 + 452;
`ifdef STOPWATCH_LAP_EN
      push(1'b0, 1'b1, 45, l2);
`endif
      pulse_at(l2, 1'b0, 1'b0, 1'b1);
      push_ticks(46, 2, e3 + 460);
      ce = e3 + 475;
      push(1'b0, 1'b0, 0, ce);
      pulse_at(ce, 1'b0, 1'b1, 1'b0);
      repeat (20) @(negedge clk);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
